// File: rtl/alu_branch_pkg.sv
// Shared constants for the execute-stage ALU / branch unit: data width,
// 4-bit ALU opcodes and a small opcode-class helper.
package alu_branch_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_ADDU  = 4'd2;
    localparam logic [3:0] ALU_SUBU  = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_NOR   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_SLL   = 4'd10;
    localparam logic [3:0] ALU_SRL   = 4'd11;
    localparam logic [3:0] ALU_SRA   = 4'd12;
    localparam logic [3:0] ALU_MULT  = 4'd13;
    localparam logic [3:0] ALU_MULTU = 4'd14;
    localparam logic [3:0] ALU_LUI   = 4'd15;

    // True for the two opcodes that write HI/LO.
    function automatic logic is_mult(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

endpackage

// File: rtl/alu_branch_unit_if.sv
// Handshake and data bundle between the control FSM (master) and the
// execute-stage ALU / branch unit (slave).
interface alu_branch_unit_if;
    import alu_branch_pkg::*;

    logic        alu_en;
    logic [3:0]  alu_control;
    word_t       read_data1;
    logic [4:0]  shamt;
    logic        select_shamt;
    word_t       alu_srcB;
    word_t       alu_result;
    word_t       hi;
    word_t       lo;
    logic        overflow;
    logic        alu_zero;
    logic        alu_done;
    logic        branch_en;
    logic        branch;
    word_t       imm;
    word_t       pc;
    word_t       pc_out;
    logic        branch_done;

    modport master (
        output alu_en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
        output branch_en, branch, imm, pc,
        input  alu_result, hi, lo, overflow, alu_zero, alu_done,
        input  pc_out, branch_done
    );

    modport slave (
        input  alu_en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
        input  branch_en, branch, imm, pc,
        output alu_result, hi, lo, overflow, alu_zero, alu_done,
        output pc_out, branch_done
    );

endinterface

// File: rtl/alu_branch_unit_alu_core.sv
// Purely combinational 16-operation ALU: result, 64-bit product,
// signed-overflow flag (ADD/SUB only) and zero flag.
module alu_core
    import alu_branch_pkg::*;
(
    input  logic [3:0]  op,
    input  word_t       src_a,
    input  word_t       src_b,
    output word_t       result,
    output logic [63:0] product,
    output logic        overflow,
    output logic        zero
);

    word_t       sum_s;
    word_t       diff_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;

    assign sum_s  = src_a + src_b;
    assign diff_s = src_a - src_b;

    // One 64-bit multiplier serves both MULT and MULTU; only the operand extension differs.
    always_comb begin
        if (op == ALU_MULT) begin
            mul_a_s = {{32{src_a[31]}}, src_a};
            mul_b_s = {{32{src_b[31]}}, src_b};
        end else begin
            mul_a_s = {32'd0, src_a};
            mul_b_s = {32'd0, src_b};
        end
    end

    assign product = mul_a_s * mul_b_s;

    // Operation select; overflow is only meaningful for the trapping-style add/sub.
    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum_s;
                overflow = (src_a[31] == src_b[31]) && (sum_s[31] != src_a[31]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (src_a[31] != src_b[31]) && (diff_s[31] != src_a[31]);
            end
            ALU_ADDU:  result = sum_s;
            ALU_SUBU:  result = diff_s;
            ALU_AND:   result = src_a & src_b;
            ALU_OR:    result = src_a | src_b;
            ALU_XOR:   result = src_a ^ src_b;
            ALU_NOR:   result = ~(src_a | src_b);
            ALU_SLT:   result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  result = (src_a < src_b) ? 32'd1 : 32'd0;
            ALU_SLL:   result = src_b << src_a[4:0];
            ALU_SRL:   result = src_b >> src_a[4:0];
            ALU_SRA:   result = $signed(src_b) >>> src_a[4:0];
            ALU_MULT:  result = product[31:0];
            ALU_MULTU: result = product[31:0];
            ALU_LUI:   result = {src_b[15:0], 16'd0};
            default:   result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_branch_unit.sv
// Execute-stage datapath: srcA mux, registered ALU results/flags/HI/LO with
// an enable/done handshake, and registered branch-target resolution with its
// own enable/done handshake. Done flags come straight from flops.
module alu_branch_unit
    import alu_branch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    alu_branch_unit_if.slave  bus
);

    word_t       src_a_s;
    word_t       core_result_s;
    logic [63:0] core_product_s;
    logic        core_overflow_s;
    logic        core_zero_s;
    word_t       branch_target_s;

    word_t       alu_result_r;
    word_t       hi_r;
    word_t       lo_r;
    logic        overflow_r;
    logic        alu_zero_r;
    logic        alu_done_r;
    word_t       pc_out_r;
    logic        branch_done_r;

    assign src_a_s = bus.select_shamt ? {27'd0, bus.shamt} : bus.read_data1;

    alu_core u_alu_core (
        .op       (bus.alu_control),
        .src_a    (src_a_s),
        .src_b    (bus.alu_srcB),
        .result   (core_result_s),
        .product  (core_product_s),
        .overflow (core_overflow_s),
        .zero     (core_zero_s)
    );

    // PC is a word index, so the offset is added without scaling.
    assign branch_target_s = bus.pc + bus.imm;

    // ALU result, flag and HI/LO registers; results hold whenever alu_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_r <= 32'd0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            overflow_r   <= 1'b0;
            alu_zero_r   <= 1'b0;
            alu_done_r   <= 1'b0;
        end else if (bus.alu_en) begin
            alu_result_r <= core_result_s;
            overflow_r   <= core_overflow_s;
            alu_zero_r   <= core_zero_s;
            alu_done_r   <= 1'b1;
            if (is_mult(bus.alu_control)) begin
                hi_r <= core_product_s[63:32];
                lo_r <= core_product_s[31:0];
            end
        end else begin
            alu_done_r <= 1'b0;
        end
    end

    // Branch resolution; uses the registered zero flag, i.e. the result from before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out_r      <= 32'd0;
            branch_done_r <= 1'b0;
        end else if (bus.branch_en) begin
            pc_out_r      <= (bus.branch && alu_zero_r) ? branch_target_s : bus.pc;
            branch_done_r <= 1'b1;
        end else begin
            branch_done_r <= 1'b0;
        end
    end

    assign bus.alu_result  = alu_result_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.overflow    = overflow_r;
    assign bus.alu_zero    = alu_zero_r;
    assign bus.alu_done    = alu_done_r;
    assign bus.pc_out      = pc_out_r;
    assign bus.branch_done = branch_done_r;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Self-checking bench for alu_branch_unit: directed test-plan steps followed
// by randomized cycles, all compared against an arithmetic reference model.
module tb_alu_branch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_branch_unit_if bus ();

    alu_branch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_result, m_hi, m_lo, m_pc_out;
    logic        m_ov, m_zero, m_alu_done, m_br_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU reference computed with wide integer arithmetic.
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ov,
                           output logic wr_hilo, output logic [63:0] prod);
        longint          s;
        longint          d;
        longint          q;
        longint unsigned u;
        int              sh;
        sh      = int'(a % 32'd32);
        res     = 32'd0;
        ov      = 1'b0;
        wr_hilo = 1'b0;
        prod    = 64'd0;
        case (op)
            4'd0: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                res = s[31:0];
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                res = s[31:0];
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  res = a + b;
            4'd3:  res = a - b;
            4'd4:  res = a & b;
            4'd5:  res = a | b;
            4'd6:  res = a ^ b;
            4'd7:  res = ~(a | b);
            4'd8:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  res = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                u   = {32'd0, b} * (64'd1 << sh);
                res = u[31:0];
            end
            4'd11: begin
                u   = {32'd0, b} / (64'd1 << sh);
                res = u[31:0];
            end
            4'd12: begin
                d = longint'(1) << sh;
                s = longint'($signed(b));
                q = s / d;
                if ((s % d) != 0 && s < 0) q = q - 1;
                res = q[31:0];
            end
            4'd13: begin
                s       = longint'($signed(a)) * longint'($signed(b));
                prod    = s;
                res     = s[31:0];
                wr_hilo = 1'b1;
            end
            4'd14: begin
                u       = {32'd0, a} * {32'd0, b};
                prod    = u;
                res     = u[31:0];
                wr_hilo = 1'b1;
            end
            4'd15: res = (b % 32'd65536) * 32'd65536;
            default: res = 32'd0;
        endcase
    endtask

    task automatic model_reset();
        m_result = 32'd0; m_hi = 32'd0; m_lo = 32'd0; m_pc_out = 32'd0;
        m_ov = 1'b0; m_zero = 1'b0; m_alu_done = 1'b0; m_br_done = 1'b0;
    endtask

    // Model behaviour at one rising edge; branch sees the zero flag from before the edge.
    task automatic model_edge();
        logic [31:0] a;
        logic [31:0] res;
        logic        ov;
        logic        wr;
        logic [63:0] prod;
        if (bus.branch_en) begin
            m_pc_out  = (bus.branch && m_zero) ? bus.pc + bus.imm : bus.pc;
            m_br_done = 1'b1;
        end else begin
            m_br_done = 1'b0;
        end
        if (bus.alu_en) begin
            a = bus.select_shamt ? {27'd0, bus.shamt} : bus.read_data1;
            ref_alu(bus.alu_control, a, bus.alu_srcB, res, ov, wr, prod);
            m_result   = res;
            m_ov       = ov;
            m_zero     = (res == 32'd0);
            m_alu_done = 1'b1;
            if (wr) begin
                m_hi = prod[63:32];
                m_lo = prod[31:0];
            end
        end else begin
            m_alu_done = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu_result"},  bus.alu_result, m_result);
        chk({tag, ".hi"},          bus.hi, m_hi);
        chk({tag, ".lo"},          bus.lo, m_lo);
        chk({tag, ".pc_out"},      bus.pc_out, m_pc_out);
        chk({tag, ".overflow"},    {31'd0, bus.overflow}, {31'd0, m_ov});
        chk({tag, ".alu_zero"},    {31'd0, bus.alu_zero}, {31'd0, m_zero});
        chk({tag, ".alu_done"},    {31'd0, bus.alu_done}, {31'd0, m_alu_done});
        chk({tag, ".branch_done"}, {31'd0, bus.branch_done}, {31'd0, m_br_done});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_alu(input logic en, input logic [3:0] op, input logic [31:0] rd1,
                           input logic sel, input logic [4:0] sh, input logic [31:0] b);
        bus.alu_en       = en;
        bus.alu_control  = op;
        bus.read_data1   = rd1;
        bus.select_shamt = sel;
        bus.shamt        = sh;
        bus.alu_srcB     = b;
    endtask

    task automatic set_br(input logic en, input logic br, input logic [31:0] pcv, input logic [31:0] immv);
        bus.branch_en = en;
        bus.branch    = br;
        bus.pc        = pcv;
        bus.imm       = immv;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_alu(1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_br(1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        step("idle");

        // ADD overflow
        set_alu(1'b1, 4'd0, 32'h7FFF_FFFF, 1'b0, 5'd0, 32'd1);
        step("add_ovf");
        chk("add_ovf.tp_result", bus.alu_result, 32'h8000_0000);
        chk("add_ovf.tp_overflow", {31'd0, bus.overflow}, 32'd1);
        chk("add_ovf.tp_done", {31'd0, bus.alu_done}, 32'd1);

        // SLL via shamt
        set_alu(1'b1, 4'd10, 32'hDEAD_BEEF, 1'b1, 5'd4, 32'h0000_000F);
        step("sll");
        chk("sll.tp_result", bus.alu_result, 32'h0000_00F0);
        chk("sll.tp_overflow", {31'd0, bus.overflow}, 32'd0);

        // SRA by 31
        set_alu(1'b1, 4'd12, 32'd0, 1'b1, 5'd31, 32'h8000_0000);
        step("sra");
        chk("sra.tp_result", bus.alu_result, 32'hFFFF_FFFF);

        // MULT -2 * 3
        set_alu(1'b1, 4'd13, 32'hFFFF_FFFE, 1'b0, 5'd0, 32'd3);
        step("mult");
        chk("mult.tp_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult.tp_lo", bus.lo, 32'hFFFF_FFFA);

        // ADD afterwards leaves HI/LO alone
        set_alu(1'b1, 4'd0, 32'd1, 1'b0, 5'd0, 32'd2);
        step("add_after_mult");
        chk("add_after_mult.tp_hi", bus.hi, 32'hFFFF_FFFF);
        chk("add_after_mult.tp_lo", bus.lo, 32'hFFFF_FFFA);

        // Branch taken: SUB 5,5 then branch
        set_alu(1'b1, 4'd1, 32'd5, 1'b0, 5'd0, 32'd5);
        step("beq_sub_eq");
        chk("beq_sub_eq.tp_zero", {31'd0, bus.alu_zero}, 32'd1);
        set_alu(1'b0, 4'd1, 32'd5, 1'b0, 5'd0, 32'd5);
        set_br(1'b1, 1'b1, 32'd10, 32'hFFFF_FFFD);
        step("br_taken");
        chk("br_taken.tp_pc_out", bus.pc_out, 32'd7);
        chk("br_taken.tp_done", {31'd0, bus.branch_done}, 32'd1);
        chk("br_taken.tp_alu_done", {31'd0, bus.alu_done}, 32'd0);

        // Branch not taken: zero clear
        set_br(1'b0, 1'b1, 32'd10, 32'hFFFF_FFFD);
        set_alu(1'b1, 4'd1, 32'd5, 1'b0, 5'd0, 32'd4);
        step("beq_sub_ne");
        set_alu(1'b0, 4'd1, 32'd5, 1'b0, 5'd0, 32'd4);
        set_br(1'b1, 1'b1, 32'd10, 32'hFFFF_FFFD);
        step("br_not_taken");
        chk("br_not_taken.tp_pc_out", bus.pc_out, 32'd10);

        // branch = 0 with zero set
        set_br(1'b0, 1'b0, 32'd10, 32'hFFFF_FFFD);
        set_alu(1'b1, 4'd1, 32'd5, 1'b0, 5'd0, 32'd5);
        step("nobr_sub_eq");
        set_alu(1'b0, 4'd1, 32'd5, 1'b0, 5'd0, 32'd5);
        set_br(1'b1, 1'b0, 32'd10, 32'hFFFF_FFFD);
        step("nobr");
        chk("nobr.tp_pc_out", bus.pc_out, 32'd10);

        // Simultaneous: branch uses zero from before the edge (still 1)
        set_alu(1'b1, 4'd1, 32'd9, 1'b0, 5'd0, 32'd4);
        set_br(1'b1, 1'b1, 32'd20, 32'd5);
        step("simul");
        chk("simul.tp_pc_out", bus.pc_out, 32'd25);
        chk("simul.tp_zero", {31'd0, bus.alu_zero}, 32'd0);

        // Drop enables: dones fall, results hold
        set_alu(1'b0, 4'd2, 32'd1, 1'b0, 5'd0, 32'd1);
        set_br(1'b0, 1'b0, 32'd0, 32'd0);
        step("drop");
        chk("drop.tp_result_hold", bus.alu_result, 32'd5);

        // Randomized cycles
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rd1;
            logic [31:0] b;
            rd1 = $urandom;
            b   = ($urandom_range(3, 0) == 0) ? rd1 : 32'($urandom);
            set_alu(1'($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)), rd1,
                    1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), b);
            set_br(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 32'($urandom), 32'($urandom));
            step("rand");
        end

        // Reset mid-request clears everything immediately
        set_alu(1'b1, 4'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0F0F_0F0F);
        set_br(1'b1, 1'b1, 32'd100, 32'd3);
        step("pre_reset");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        step("after_reset");
        chk("after_reset.tp_done", {31'd0, bus.alu_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_branch_unit.md
# alu_branch_unit

Execute-stage datapath for the multi-cycle MIPS core: operand-A selection (register or shift amount), a 16-operation 32-bit ALU with HI/LO multiply results, and branch-target resolution. The control FSM drives it with separate enable/done handshakes: one for the ALU (EXECUTE state) and one for the branch (BRANCH state). PC is a word index, so the branch offset is added unscaled.

## Interface
Parameters: none. All opcodes are fixed constants in the shared package.

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- alu_en  in  1  ALU request; held high until alu_done is observed
- alu_control  in  4  ALU operation code
- read_data1  in  32  rs register value
- shamt  in  5  instruction shift amount
- select_shamt  in  1  1: srcA = zero-extended shamt; 0: srcA = read_data1
- alu_srcB  in  32  rt value or extended immediate, selected upstream
- alu_result  out  32  registered result
- hi, lo  out  32 each  registered multiply product halves
- overflow  out  1  signed overflow of the last ADD/SUB
- alu_zero  out  1  registered (alu_result == 0)
- alu_done  out  1  ALU handshake completion
- branch_en  in  1  branch request; held high until branch_done is observed
- branch  in  1  instruction is a branch
- imm  in  32  sign-extended branch offset, in words
- pc  in  32  already-incremented PC (PC+1)
- pc_out  out  32  next PC
- branch_done  out  1  branch handshake completion

## Operation
- srcA is a combinational mux: select_shamt ? {27'b0, shamt} : read_data1.
- Opcodes: 0 ADD, 1 SUB, 2 ADDU, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 MULT (signed), 14 MULTU, 15 LUI.
- Shift amount is srcA[4:0]:
  - SLL: srcB << srcA[4:0]
  - SRL: logical right shift of srcB
  - SRA: arithmetic right shift of srcB
- LUI: result = {srcB[15:0], 16'b0}.
- SLT/SLTU: result = 32'd1 if srcA < srcB (signed/unsigned), else 0.
- MULT/MULTU:
  - {hi, lo} = 64-bit product of srcA and srcB.
  - alu_result = low 32 bits of the product.
  - hi and lo change only on these two ops; they hold otherwise.
- Overflow:
  - ADD/SUB set overflow on two's-complement overflow; every other op clears it.
  - Results wrap modulo 2^32; no trap.
- alu_zero is registered together with alu_result and reflects the new result.
- Branch: if branch && alu_zero then pc_out = pc + imm (mod 2^32), else pc_out = pc. BEQ is executed as SUB in EXECUTE beforehand.

## Timing
- Reset (async):
  - alu_result, hi, lo, pc_out = 0
  - overflow, alu_zero, alu_done, branch_done = 0
- ALU:
  - On each edge with alu_en = 1: result, flags and (for multiply) hi/lo are computed from the current inputs and registered; alu_done <= 1.
  - Latency is 1 cycle from the first edge with alu_en high.
  - While alu_en stays high, the ALU recomputes every cycle and alu_done stays 1.
  - On an edge with alu_en = 0: alu_done <= 0; all results hold.
- Branch:
  - On each edge with branch_en = 1: pc_out registered, branch_done <= 1.
  - On an edge with branch_en = 0: branch_done <= 0 and pc_out holds.
- Simultaneous alu_en and branch_en: the branch uses the alu_zero value from before the edge (the previous ALU result).
- Reset mid-operation: all outputs clear immediately. The requester must re-assert its enable to get a fresh done.
- No combinational path from any input to alu_done or branch_done.

## Structure
- Shared package alu_branch_pkg: 4-bit opcode localparams (ALU_ADD … ALU_LUI), data-width constant 32.
- One sub-module, alu_core: purely combinational. It takes opcode, srcA and srcB and produces the result, 64-bit product, overflow and zero flag.
- The top level holds:
  - the srcA mux;
  - the result/flag/HI/LO registers and their done logic;
  - the branch adder and its registers and done logic.

## Test plan
- ADD: srcA = 0x7FFFFFFF, srcB = 1, pulse alu_en -> next cycle alu_result = 0x80000000, overflow = 1, alu_zero = 0, alu_done = 1.
- SLL via shamt: select_shamt = 1, shamt = 4, srcB = 0x0000000F, op 10 -> 0x000000F0. SRA with srcB = 0x80000000, shamt = 31 -> 0xFFFFFFFF.
- MULT: srcA = -2, srcB = 3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. A following ADD leaves hi/lo unchanged.
- Branch taken: SUB with 5, 5 (alu_zero = 1), then branch = 1, pc = 10, imm = 0xFFFFFFFD, branch_en -> pc_out = 7, branch_done = 1.
- Branch not taken: alu_zero = 0, pc = 10 -> pc_out = 10. Also branch = 0 with alu_zero = 1 -> pc_out = 10.
- Handshake: drop alu_en -> alu_done = 0 next edge, results hold. Assert reset mid-request -> every output 0 immediately.
